// File: rtl/job_dispatch_pkg.sv
// job_dispatch_pkg: shared encodings for the job dispatcher.
//   - dispatch FSM state (D_IDLE, D_OFFER)
//   - engine ownership state (FREE, BUSY)
//   - process_info field offsets (init_addr at [63:0], PASID above it)
//   - popcount helper used by the optional completion statistics
package job_dispatch_pkg;

    typedef enum logic {
        D_IDLE  = 1'b0,
        D_OFFER = 1'b1
    } disp_state_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } eng_state_e;

    // Descriptor layout: {pad, flags[7:0], pasid, init_addr[63:0]}
    localparam int PINFO_ADDR_LSB  = 0;
    localparam int PINFO_ADDR_W    = 64;
    localparam int PINFO_PASID_LSB = PINFO_ADDR_LSB + PINFO_ADDR_W;

    // Engine count is capped at 8, so an 8-bit popcount covers every config.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/jd_fifo.sv
// jd_fifo: job queue for the dispatcher.
// Synchronous FIFO with first-word-fall-through head, a level counter that
// decides full/empty, and a registered ready flag.
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   push_i / push_data_i   write strobe and data (ignored when full)
//   pop_i           consume the head (caller guarantees non-empty)
//   head_o          current head entry
//   level_o         number of queued entries
//   empty_o         queue empty
//   ready_o         registered "not full"; 0 while in reset
module jd_fifo #(
    parameter int WIDTH = 88,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [LW-1:0]    level_o,
    output logic             empty_o,
    output logic             ready_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ready_q, ready_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // Registered from the next level: a pop while full does not reopen
        // the queue until the following cycle.
        ready_d = (level_d != LW'(DEPTH));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/job_dispatcher.sv
// job_dispatcher: queues process-start requests and hands them out to
// NUM_ENGINES action engines by round-robin.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   process_start_i/info_i      job request handshake from the MMIO front end
//   process_ready_o             queue can accept
//   eng_start_o/eng_info_o      one-hot offer and shared descriptor
//   eng_ready_i                 engine accepts the offer
//   eng_done_i                  per-engine job-complete pulse
//   eng_busy_o                  engine owns a job
//   fifo_level_o                queued job count
//   done_err_o/done_err_pasid_o sticky error for done from a non-busy engine
// Optional (macro JOB_DISPATCH_STATS_EN):
//   stat_dispatched_o           accepted offers, wrapping 32-bit counter
//   stat_completed_o            valid dones, wrapping 32-bit counter
module job_dispatcher
    import job_dispatch_pkg::*;
#(
    parameter int PINFO_WIDTH = 88,
    parameter int PASID_WIDTH = 9,
    parameter int NUM_ENGINES = 4,
    parameter int FIFO_DEPTH  = 8,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   process_start_i,
    input  logic [PINFO_WIDTH-1:0] process_info_i,
    output logic                   process_ready_o,
    output logic [NUM_ENGINES-1:0] eng_start_o,
    output logic [PINFO_WIDTH-1:0] eng_info_o,
    input  logic [NUM_ENGINES-1:0] eng_ready_i,
    input  logic [NUM_ENGINES-1:0] eng_done_i,
    output logic [NUM_ENGINES-1:0] eng_busy_o,
    output logic [LW-1:0]          fifo_level_o,
    output logic                   done_err_o,
    output logic [PASID_WIDTH-1:0] done_err_pasid_o
`ifdef JOB_DISPATCH_STATS_EN
    ,
    output logic [31:0]            stat_dispatched_o,
    output logic [31:0]            stat_completed_o
`endif
);

    localparam int GW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    // Queue
    logic                   fifo_ready;
    logic                   fifo_empty;
    logic [PINFO_WIDTH-1:0] fifo_head;
    logic                   push;
    logic                   pop;

    // Dispatch state
    disp_state_e            state_q, state_d;
    logic [NUM_ENGINES-1:0] start_q, start_d;
    logic [PINFO_WIDTH-1:0] info_q, info_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          rr_q, rr_d;

    // Engine state and error tracking
    eng_state_e             eng_q [NUM_ENGINES];
    eng_state_e             eng_d [NUM_ENGINES];
    logic [NUM_ENGINES-1:0][PASID_WIDTH-1:0] last_pasid_q, last_pasid_d;
    logic                   err_q, err_d;
    logic [PASID_WIDTH-1:0] err_pasid_q, err_pasid_d;

    logic [NUM_ENGINES-1:0] busy_vec;
    logic [NUM_ENGINES-1:0] eligible;
    logic [NUM_ENGINES-1:0] valid_done;
    logic [NUM_ENGINES-1:0] spurious_done;
    logic                   arb_found;
    logic [GW-1:0]          arb_gnt;
    logic                   accept;

    assign push = process_start_i & fifo_ready;

    jd_fifo #(
        .WIDTH (PINFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (push),
        .push_data_i (process_info_i),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .level_o     (fifo_level_o),
        .empty_o     (fifo_empty),
        .ready_o     (fifo_ready)
    );

    always_comb begin
        for (int k = 0; k < NUM_ENGINES; k++) begin
            busy_vec[k] = (eng_q[k] == BUSY);
        end
    end

    // An engine currently being offered is not BUSY yet but must not be
    // offered a second job.
    assign eligible      = ~busy_vec & ~start_q;
    assign valid_done    = eng_done_i & busy_vec;
    assign spurious_done = eng_done_i & ~busy_vec;

    // Round-robin: first eligible engine at or after rr_q, wrapping.
    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_gnt   = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            idx = (int'(rr_q) + i) % NUM_ENGINES;
            if (!arb_found && eligible[idx]) begin
                arb_found = 1'b1;
                arb_gnt   = GW'(idx);
            end
        end
    end

    assign pop    = (state_q == D_IDLE) && !fifo_empty && arb_found;
    assign accept = (state_q == D_OFFER) && eng_ready_i[grant_q];

    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        info_d       = info_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        last_pasid_d = last_pasid_q;
        err_d        = err_q;
        err_pasid_d  = err_pasid_q;

        case (state_q)
            D_IDLE: begin
                if (pop) begin
                    state_d          = D_OFFER;
                    info_d           = fifo_head;
                    grant_d          = arb_gnt;
                    start_d          = '0;
                    start_d[arb_gnt] = 1'b1;
                end
            end
            D_OFFER: begin
                if (accept) begin
                    state_d = D_IDLE;
                    start_d = '0;
                    rr_d    = (grant_q == GW'(NUM_ENGINES - 1)) ? '0 : grant_q + 1'b1;
                    last_pasid_d[grant_q] = info_q[PINFO_PASID_LSB +: PASID_WIDTH];
                end
            end
            default: state_d = D_IDLE;
        endcase

        // The offered engine is never BUSY, so accept and a valid done can
        // not collide on the same engine.
        for (int k = 0; k < NUM_ENGINES; k++) begin
            eng_d[k] = eng_q[k];
            if (accept && (int'(grant_q) == k)) begin
                eng_d[k] = BUSY;
            end else if (valid_done[k]) begin
                eng_d[k] = FREE;
            end
        end

        // Lowest-numbered offender wins when several spurious dones coincide.
        for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
            if (spurious_done[k]) begin
                err_d       = 1'b1;
                err_pasid_d = last_pasid_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= D_IDLE;
            start_q      <= '0;
            info_q       <= '0;
            grant_q      <= '0;
            rr_q         <= '0;
            last_pasid_q <= '0;
            err_q        <= 1'b0;
            err_pasid_q  <= '0;
            for (int k = 0; k < NUM_ENGINES; k++) begin
                eng_q[k] <= FREE;
            end
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            info_q       <= info_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            last_pasid_q <= last_pasid_d;
            err_q        <= err_d;
            err_pasid_q  <= err_pasid_d;
            for (int k = 0; k < NUM_ENGINES; k++) begin
                eng_q[k] <= eng_d[k];
            end
        end
    end

    assign process_ready_o  = fifo_ready;
    assign eng_start_o      = start_q;
    assign eng_info_o       = info_q;
    assign eng_busy_o       = busy_vec;
    assign done_err_o       = err_q;
    assign done_err_pasid_o = err_pasid_q;

`ifdef JOB_DISPATCH_STATS_EN
    logic [31:0] stat_disp_q, stat_disp_d;
    logic [31:0] stat_comp_q, stat_comp_d;

    always_comb begin
        logic [7:0] done_pad;
        done_pad                  = '0;
        done_pad[NUM_ENGINES-1:0] = valid_done;
        stat_disp_d = stat_disp_q + {31'b0, accept};
        stat_comp_d = stat_comp_q + {28'b0, popcount8(done_pad)};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_disp_q <= '0;
            stat_comp_q <= '0;
        end else begin
            stat_disp_q <= stat_disp_d;
            stat_comp_q <= stat_comp_d;
        end
    end

    assign stat_dispatched_o = stat_disp_q;
    assign stat_completed_o  = stat_comp_q;
`endif

endmodule

// File: tb/tb_job_dispatcher.sv
module tb_job_dispatcher;

    localparam int NE = 4;
    localparam int PW = 88;
    localparam int DEPTH = 8;
    localparam logic [PW-1:0] JOB1 = 88'h001005DEADBEEF00001000;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [PW-1:0] info;
    logic          process_ready;
    logic [NE-1:0] eng_start;
    logic [PW-1:0] eng_info;
    logic [NE-1:0] eng_ready;
    logic [NE-1:0] eng_done;
    logic [NE-1:0] eng_busy;
    logic [3:0]    fifo_level;
    logic          done_err;
    logic [8:0]    done_err_pasid;
`ifdef JOB_DISPATCH_STATS_EN
    logic [31:0]   stat_dispatched;
    logic [31:0]   stat_completed;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    job_dispatcher dut (
        .clk              (clk),
        .resetn           (resetn),
        .process_start_i  (start),
        .process_info_i   (info),
        .process_ready_o  (process_ready),
        .eng_start_o      (eng_start),
        .eng_info_o       (eng_info),
        .eng_ready_i      (eng_ready),
        .eng_done_i       (eng_done),
        .eng_busy_o       (eng_busy),
        .fifo_level_o     (fifo_level),
        .done_err_o       (done_err),
        .done_err_pasid_o (done_err_pasid)
`ifdef JOB_DISPATCH_STATS_EN
        ,
        .stat_dispatched_o(stat_dispatched),
        .stat_completed_o (stat_completed)
`endif
    );

    // ---------------- reference model (transaction level) ----------------
    logic [PW-1:0] mq[$];       // queued descriptors, head first
    bit            mbusy[NE];   // engine owns a job
    int            moff;        // engine being offered, -1 if none
    logic [PW-1:0] minfo;       // descriptor on offer
    int            mrr;         // next engine to try first
    logic [8:0]    mlast[NE];   // pasid last handed to each engine
    bit            merr;
    logic [8:0]    merrp;
    bit            mready;
    int unsigned   mdisp;
    int unsigned   mcomp;

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < NE; k++) begin
            mbusy[k] = 0;
            mlast[k] = '0;
        end
        moff = -1; minfo = '0; mrr = 0;
        merr = 0; merrp = '0; mready = 0;
        mdisp = 0; mcomp = 0;
    endtask

    // One clock edge of the job-level rules, applied to the inputs present.
    task automatic model_step();
        bit         ob[NE];
        logic [8:0] ol[NE];
        bit         psh;
        ob  = mbusy;
        ol  = mlast;
        psh = start && mready;
        if (moff >= 0) begin
            if (eng_ready[moff]) begin
                mbusy[moff] = 1;
                mlast[moff] = minfo[72:64];
                mrr  = (moff + 1) % NE;
                moff = -1;
                mdisp++;
            end
        end else if (mq.size() > 0) begin
            for (int i = 0; i < NE; i++) begin
                int e;
                e = (mrr + i) % NE;
                if (!ob[e]) begin
                    moff  = e;
                    minfo = mq.pop_front();
                    break;
                end
            end
        end
        for (int k = NE - 1; k >= 0; k--) begin
            if (eng_done[k]) begin
                if (ob[k]) begin
                    mbusy[k] = 0;
                    mcomp++;
                end else begin
                    merr  = 1;
                    merrp = ol[k];
                end
            end
        end
        if (psh) mq.push_back(info);
        mready = (mq.size() != DEPTH);
    endtask

    function automatic logic [NE-1:0] exp_start();
        logic [NE-1:0] v;
        v = '0;
        if (moff >= 0) v[moff] = 1'b1;
        return v;
    endfunction

    function automatic logic [NE-1:0] exp_busy();
        logic [NE-1:0] v;
        for (int k = 0; k < NE; k++) v[k] = mbusy[k];
        return v;
    endfunction

    function automatic logic [PW-1:0] rand_info();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[PW-1:0];
    endfunction

    // Inputs change after the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; start = 1'b0; info = '0; eng_ready = '0; eng_done = '0;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; info = '0; eng_ready = '0; eng_done = '0;
        model_reset();
        repeat (2) @(negedge clk);
        nvec++;
        if (process_ready !== 1'b0 || eng_start !== '0 || eng_info !== '0 || eng_busy !== '0 ||
            fifo_level !== '0 || done_err !== 1'b0 || done_err_pasid !== '0) begin
            nerr++;
            $display("FAIL reset_state: rdy=%b start=%b busy=%b lvl=%0d err=%b pasid=%h, want all 0",
                     process_ready, eng_start, eng_busy, fifo_level, done_err, done_err_pasid);
        end
        resetn = 1'b1;
        tick();
        nvec++;
        if (process_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_release_ready: got %b want 1", process_ready);
        end
    endtask

    task automatic test_single_job();
        do_reset();
        info = JOB1; start = 1'b1;
        tick();
        start = 1'b0;
        nvec++;
        if (eng_start !== 4'b0000 || fifo_level !== 4'd1) begin
            nerr++;
            $display("FAIL single_push: start=%b lvl=%0d want 0000/1", eng_start, fifo_level);
        end
        tick();
        nvec++;
        if (eng_start !== 4'b0001 || eng_info !== JOB1 || fifo_level !== 4'd0) begin
            nerr++;
            $display("FAIL single_offer: start=%b info=%h lvl=%0d want 0001/%h/0",
                     eng_start, eng_info, fifo_level, JOB1);
        end
        eng_ready = 4'b0001;
        tick();
        eng_ready = '0;
        nvec++;
        if (eng_busy !== 4'b0001 || eng_start !== 4'b0000) begin
            nerr++;
            $display("FAIL single_accept: busy=%b start=%b want 0001/0000", eng_busy, eng_start);
        end
        eng_done = 4'b0001;
        tick();
        eng_done = '0;
        nvec++;
        if (eng_busy !== 4'b0000 || done_err !== 1'b0) begin
            nerr++;
            $display("FAIL single_done: busy=%b err=%b want 0000/0", eng_busy, done_err);
        end
    endtask

    task automatic test_round_robin();
        logic [NE-1:0] grants[$];
        do_reset();
        eng_ready = 4'hF;
        for (int j = 0; j < 6; j++) begin
            info = rand_info(); start = 1'b1;
            tick();
            if (eng_start !== '0) grants.push_back(eng_start);
        end
        start = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (eng_start !== '0) grants.push_back(eng_start);
        end
        nvec++;
        if (grants.size() != 4) begin
            nerr++;
            $display("FAIL rr_grant_count: got %0d want 4", grants.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                logic [NE-1:0] w;
                w = '0; w[j] = 1'b1;
                nvec++;
                if (grants[j] !== w) begin
                    nerr++;
                    $display("FAIL rr_grant_%0d: got %b want %b", j, grants[j], w);
                end
            end
        end
        nvec++;
        if (eng_start !== 4'b0000 || fifo_level !== 4'd2 || eng_busy !== 4'hF) begin
            nerr++;
            $display("FAIL rr_stall: start=%b lvl=%0d busy=%b want 0000/2/1111", eng_start, fifo_level, eng_busy);
        end
        eng_done = 4'b0100;
        tick();
        eng_done = '0;
        tick();
        nvec++;
        if (eng_start !== 4'b0100 || fifo_level !== 4'd1) begin
            nerr++;
            $display("FAIL rr_after_done: start=%b lvl=%0d want 0100/1", eng_start, fifo_level);
        end
        eng_ready = '0;
    endtask

    task automatic test_full_fifo();
        int n;
        do_reset();
        eng_ready = 4'hF;
        info = rand_info(); start = 1'b1;
        n = 0;
        while (!(mq.size() == DEPTH && exp_busy() == 4'hF) && n < 60) begin
            bit acc;
            acc = start && mready;
            tick();
            if (acc) info = rand_info();
            n++;
        end
        nvec++;
        if (process_ready !== 1'b0 || fifo_level !== 4'd8 || eng_busy !== 4'hF) begin
            nerr++;
            $display("FAIL full_state: rdy=%b lvl=%0d busy=%b want 0/8/1111 (n=%0d)",
                     process_ready, fifo_level, eng_busy, n);
        end
        tick();
        nvec++;
        if (process_ready !== 1'b0 || fifo_level !== 4'd8) begin
            nerr++;
            $display("FAIL full_hold: rdy=%b lvl=%0d want 0/8", process_ready, fifo_level);
        end
        eng_done = 4'b0010;
        tick();
        eng_done = '0;
        tick();
        nvec++;
        if (process_ready !== 1'b1 || fifo_level !== 4'd7 || eng_start !== 4'b0010) begin
            nerr++;
            $display("FAIL full_pop: rdy=%b lvl=%0d start=%b want 1/7/0010", process_ready, fifo_level, eng_start);
        end
        start = 1'b0; eng_ready = '0;
    endtask

    task automatic test_spurious_done();
        do_reset();
        eng_ready = 4'hF;
        for (int j = 0; j < 4; j++) begin
            info = rand_info();
            if (j == 3) info[72:64] = 9'h1A5;
            else        info[72:64] = 9'h0F0;
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        for (int j = 0; j < 10; j++) tick();
        eng_done = 4'b1000;
        tick();
        eng_done = '0;
        nvec++;
        if (eng_busy !== 4'b0111 || done_err !== 1'b0) begin
            nerr++;
            $display("FAIL spur_valid_done: busy=%b err=%b want 0111/0", eng_busy, done_err);
        end
        eng_done = 4'b1000;
        tick();
        eng_done = '0;
        nvec++;
        if (done_err !== 1'b1 || done_err_pasid !== 9'h1A5 || eng_busy !== 4'b0111) begin
            nerr++;
            $display("FAIL spur_err: err=%b pasid=%h busy=%b want 1/1a5/0111", done_err, done_err_pasid, eng_busy);
        end
        tick();
        nvec++;
        if (done_err !== 1'b1) begin
            nerr++;
            $display("FAIL spur_sticky: err=%b want 1", done_err);
        end
        eng_ready = '0;
    endtask

    task automatic test_stalled_offer();
        logic [NE-1:0] s;
        logic [PW-1:0] i;
        int n;
        do_reset();
        for (int j = 0; j < 2; j++) begin
            info = rand_info(); start = 1'b1;
            tick();
        end
        start = 1'b0;
        n = 0;
        while (eng_start === '0 && n < 10) begin tick(); n++; end
        s = eng_start; i = eng_info;
        nvec++;
        if (s !== exp_start() || i !== minfo) begin
            nerr++;
            $display("FAIL stall_first: start=%b want %b", s, exp_start());
        end
        for (int j = 0; j < 5; j++) begin
            tick();
            nvec++;
            if (eng_start !== s || eng_info !== i || fifo_level !== 4'd1) begin
                nerr++;
                $display("FAIL stall_hold_%0d: start=%b lvl=%0d want %b/1", j, eng_start, fifo_level, s);
            end
        end
        eng_ready = s;
        tick();
        eng_ready = '0;
        nvec++;
        if (eng_start !== 4'b0000 || eng_busy !== s) begin
            nerr++;
            $display("FAIL stall_accept: start=%b busy=%b want 0000/%b", eng_start, eng_busy, s);
        end
    endtask

    task automatic test_reset_mid_job();
        do_reset();
        for (int j = 0; j < 4; j++) begin
            info = rand_info(); start = 1'b1;
            tick();
        end
        start = 1'b0;
        nvec++;
        if (fifo_level !== 4'd3 || eng_start !== 4'b0001) begin
            nerr++;
            $display("FAIL midrst_setup: lvl=%0d start=%b want 3/0001", fifo_level, eng_start);
        end
        resetn = 1'b0;
        model_reset();
        #1;
        nvec++;
        if (process_ready !== 1'b0 || eng_start !== '0 || eng_info !== '0 || eng_busy !== '0 ||
            fifo_level !== '0 || done_err !== 1'b0 || done_err_pasid !== '0) begin
            nerr++;
            $display("FAIL midrst_state: rdy=%b start=%b busy=%b lvl=%0d err=%b",
                     process_ready, eng_start, eng_busy, fifo_level, done_err);
        end
`ifdef JOB_DISPATCH_STATS_EN
        nvec++;
        if (stat_dispatched !== 32'd0 || stat_completed !== 32'd0) begin
            nerr++;
            $display("FAIL midrst_stats: disp=%0d comp=%0d want 0/0", stat_dispatched, stat_completed);
        end
`endif
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bit acc;
            if (!start && $urandom_range(0, 2) != 0) begin
                start = 1'b1;
                info  = rand_info();
            end
            eng_ready = NE'($urandom());
            eng_done  = '0;
            for (int k = 0; k < NE; k++) begin
                if (mbusy[k] && $urandom_range(0, 5) == 0) eng_done[k] = 1'b1;
                else if (!mbusy[k] && $urandom_range(0, 199) == 0) eng_done[k] = 1'b1;
            end
            acc = start && mready;
            tick();
            if (acc) start = 1'b0;
            nvec++;
            if (eng_start !== exp_start() || eng_busy !== exp_busy() || fifo_level !== 4'(mq.size()) ||
                process_ready !== mready || done_err !== merr || done_err_pasid !== merrp ||
                (moff >= 0 && eng_info !== minfo)) begin
                nerr++;
                $display("FAIL random_c%0d: start=%b/%b busy=%b/%b lvl=%0d/%0d rdy=%b/%b err=%b/%b pasid=%h/%h",
                         c, eng_start, exp_start(), eng_busy, exp_busy(), fifo_level, mq.size(),
                         process_ready, mready, done_err, merr, done_err_pasid, merrp);
            end
`ifdef JOB_DISPATCH_STATS_EN
            nvec++;
            if (stat_dispatched !== mdisp || stat_completed !== mcomp) begin
                nerr++;
                $display("FAIL random_stats_c%0d: disp=%0d/%0d comp=%0d/%0d",
                         c, stat_dispatched, mdisp, stat_completed, mcomp);
            end
`endif
        end
        start = 1'b0; eng_ready = '0; eng_done = '0;
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_full_fifo();
        test_spurious_done();
        test_stalled_offer();
        test_reset_mid_job();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
